// File: rtl/c5_ctrl.sv
// c5_ctrl: sequencer for LeNet conv layer C5 (16x5x5 f5 map -> 120-entry f6 vector).
// Issues one kernel tap per cycle for every output channel and steers the external MAC.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   c5_start   start pulse, honoured only while idle
//   f5_raddr   f5 read address (tap index), registered
//   w_raddr    weight read address (oc*TAPS+tap), registered
//   c5_clr     MAC loads instead of accumulating; aligned with tap-0 RAM data
//   c5_acc_en  MAC consumes the current product; aligned with RAM data
//   f6_waddr   f6 write address (output channel), holds between writes
//   f6_wr_en   one-cycle f6 write strobe
//   c5_busy    high while issuing or flushing
//   c5_done    one-cycle end-of-layer pulse
module c5_ctrl #(
   parameter int unsigned OUT_CH   = 120,
   parameter int unsigned TAPS     = 25,
   parameter int unsigned DATA_LAT = 1,
   parameter int unsigned MAC_LAT  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        c5_start,
   output logic [4:0]  f5_raddr,
   output logic [11:0] w_raddr,
   output logic        c5_clr,
   output logic        c5_acc_en,
   output logic [6:0]  f6_waddr,
   output logic        f6_wr_en,
   output logic        c5_busy,
   output logic        c5_done
);

   // Stage counts measured from the issue cycle.
   localparam int unsigned AccLen   = 1 + DATA_LAT;
   localparam int unsigned WrLen    = AccLen + MAC_LAT;
   localparam int unsigned FlushLen = DATA_LAT + MAC_LAT + 1;

   typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

   state_e             state_q, state_d;
   logic [4:0]         tap_q, tap_d;
   logic [6:0]         oc_q, oc_d;
   logic [11:0]        wcnt_q, wcnt_d;
   logic [2:0]         flush_q, flush_d;
   logic [6:0]         wr_idx_q;
   logic [4:0]         f5_raddr_q;
   logic [11:0]        w_raddr_q;
   logic [6:0]         f6_waddr_q;
   logic [AccLen-1:0]  acc_v_q;
   logic [AccLen-1:0]  clr_v_q;
   logic [WrLen-1:0]   wr_v_q;

   logic issue, issue_clr, issue_last, start_acc;

   always_comb begin
      state_d    = state_q;
      tap_d      = tap_q;
      oc_d       = oc_q;
      wcnt_d     = wcnt_q;
      flush_d    = flush_q;
      issue      = 1'b0;
      issue_clr  = 1'b0;
      issue_last = 1'b0;
      start_acc  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (c5_start) begin
               start_acc = 1'b1;
               state_d   = StRun;
               tap_d     = '0;
               oc_d      = '0;
               wcnt_d    = '0;
            end
         end
         StRun: begin
            issue      = 1'b1;
            issue_clr  = (tap_q == 5'd0);
            issue_last = (tap_q == 5'(TAPS - 1));
            wcnt_d     = wcnt_q + 12'd1;
            if (tap_q == 5'(TAPS - 1)) begin
               tap_d = '0;
               if (oc_q == 7'(OUT_CH - 1)) begin
                  state_d = StFlush;
                  flush_d = '0;
               end else begin
                  oc_d = oc_q + 7'd1;
               end
            end else begin
               tap_d = tap_q + 5'd1;
            end
         end
         StFlush: begin
            // Wait for the final MAC result to be written before signalling done.
            if (flush_q == 3'(FlushLen - 1)) begin
               state_d = StDone;
            end else begin
               flush_d = flush_q + 3'd1;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         tap_q      <= '0;
         oc_q       <= '0;
         wcnt_q     <= '0;
         flush_q    <= '0;
         wr_idx_q   <= '0;
         f5_raddr_q <= '0;
         w_raddr_q  <= '0;
         f6_waddr_q <= '0;
         acc_v_q    <= '0;
         clr_v_q    <= '0;
         wr_v_q     <= '0;
      end else begin
         state_q <= state_d;
         tap_q   <= tap_d;
         oc_q    <= oc_d;
         wcnt_q  <= wcnt_d;
         flush_q <= flush_d;
         acc_v_q <= {acc_v_q[AccLen-2:0], issue};
         clr_v_q <= {clr_v_q[AccLen-2:0], issue_clr};
         wr_v_q  <= {wr_v_q[WrLen-2:0], issue_last};
         if (issue) begin
            f5_raddr_q <= tap_q;
            w_raddr_q  <= wcnt_q;
         end
         // Channel index advances one stage ahead so it lines up with the write strobe.
         if (start_acc) begin
            wr_idx_q <= '0;
         end else if (wr_v_q[WrLen-2]) begin
            f6_waddr_q <= wr_idx_q;
            wr_idx_q   <= wr_idx_q + 7'd1;
         end
      end
   end

   assign f5_raddr  = f5_raddr_q;
   assign w_raddr   = w_raddr_q;
   assign f6_waddr  = f6_waddr_q;
   assign c5_acc_en = acc_v_q[AccLen-1];
   assign c5_clr    = clr_v_q[AccLen-1];
   assign f6_wr_en  = wr_v_q[WrLen-1];
   assign c5_busy   = (state_q == StRun) || (state_q == StFlush);
   assign c5_done   = (state_q == StDone);

endmodule

// File: tb/tb_c5_ctrl.sv
module tb_c5_ctrl;

   localparam int Taps    = 25;
   localparam int OutCh   = 120;
   localparam int DataLat = 1;
   localparam int MacLat  = 2;
   localparam int RunLen  = Taps * OutCh;               // 3000
   localparam int WrFirst = Taps - 1 + 1 + DataLat + MacLat; // 28
   localparam int DoneK   = RunLen - 1 + 1 + DataLat + MacLat + 1; // 3004

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        c5_start = 1'b0;
   logic [4:0]  f5_raddr;
   logic [11:0] w_raddr;
   logic        c5_clr, c5_acc_en, f6_wr_en, c5_busy, c5_done;
   logic [6:0]  f6_waddr;

   int checks = 0;
   int errors = 0;

   c5_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .c5_start (c5_start),
      .f5_raddr (f5_raddr),
      .w_raddr  (w_raddr),
      .c5_clr   (c5_clr),
      .c5_acc_en(c5_acc_en),
      .f6_waddr (f6_waddr),
      .f6_wr_en (f6_wr_en),
      .c5_busy  (c5_busy),
      .c5_done  (c5_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 30) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a run is described only by the cycle it began; every output is
   // derived from the offset k into that run.
   int  cyc = 0;
   int  run_start = 0;
   bit  active = 0;
   bit  chk_en = 0;
   int  e_f5 = 0, e_w = 0, e_waddr = 0;
   bit  e_clr, e_acc, e_wr, e_busy, e_done;

   always @(posedge clk) begin
      int k;
      if (rst) begin
         active  = 0;
         e_f5    = 0;
         e_w     = 0;
         e_waddr = 0;
         chk_en  = 1;
      end else if (c5_start && (!active || (cyc - run_start) > DoneK)) begin
         active    = 1;
         run_start = cyc + 1;
      end
      cyc = cyc + 1;
      k = cyc - run_start;
      e_busy = active && k >= 0 && k < DoneK;
      e_done = active && k == DoneK;
      e_acc  = active && k >= 1 + DataLat && k < RunLen + 1 + DataLat;
      e_clr  = e_acc && ((k - 1 - DataLat) % Taps == 0);
      e_wr   = active && k >= WrFirst && k < DoneK && ((k - WrFirst) % Taps == 0);
      if (e_wr) e_waddr = (k - WrFirst) / Taps;
      if (active && k >= 1 && k <= RunLen) begin
         e_f5 = (k - 1) % Taps;
         e_w  = k - 1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("f5_raddr", int'(f5_raddr), e_f5);
         chk("w_raddr", int'(w_raddr), e_w);
         chk("c5_clr", int'(c5_clr), int'(e_clr));
         chk("c5_acc_en", int'(c5_acc_en), int'(e_acc));
         chk("f6_wr_en", int'(f6_wr_en), int'(e_wr));
         chk("f6_waddr", int'(f6_waddr), e_waddr);
         chk("c5_busy", int'(c5_busy), int'(e_busy));
         chk("c5_done", int'(c5_done), int'(e_done));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full run with literal spot checks; stray starts at k=10 and k=DoneK when requested.
   task automatic full_run(input bit stray);
      int n_acc = 0, n_clr = 0, n_wr = 0, n_done = 0;
      c5_start = 1'b1;
      step();
      for (int k = 0; k < DoneK + 6; k++) begin
         c5_start = stray && (k == 10 || k == DoneK);
         @(negedge clk);
         n_acc  += int'(c5_acc_en);
         n_clr  += int'(c5_clr);
         n_wr   += int'(f6_wr_en);
         n_done += int'(c5_done);
         if (k == 0) chk("lit busy k0", int'(c5_busy), 1);
         if (k == 1) begin
            chk("lit f5 k1", int'(f5_raddr), 0);
            chk("lit w k1", int'(w_raddr), 0);
         end
         if (k == 2) chk("lit clr k2", int'(c5_clr), 1);
         if (k == 25) chk("lit f5 k25", int'(f5_raddr), 24);
         if (k == 26) begin
            chk("lit f5 k26", int'(f5_raddr), 0);
            chk("lit w k26", int'(w_raddr), 25);
         end
         if (k == 27) chk("lit clr k27", int'(c5_clr), 1);
         if (k == 28) begin
            chk("lit wr k28", int'(f6_wr_en), 1);
            chk("lit waddr k28", int'(f6_waddr), 0);
         end
         if (k == 53) chk("lit waddr k53", int'(f6_waddr), 1);
         if (k == 2977) chk("lit clr k2977", int'(c5_clr), 1);
         if (k == 3003) begin
            chk("lit wr k3003", int'(f6_wr_en), 1);
            chk("lit waddr k3003", int'(f6_waddr), 119);
            chk("lit busy k3003", int'(c5_busy), 1);
         end
         if (k == 3004) begin
            chk("lit done k3004", int'(c5_done), 1);
            chk("lit busy k3004", int'(c5_busy), 0);
         end
         if (k == 3008) begin
            chk("lit f5 hold", int'(f5_raddr), 24);
            chk("lit w hold", int'(w_raddr), 2999);
         end
         step();
      end
      c5_start = 1'b0;
      chk("count acc_en", n_acc, 3000);
      chk("count clr", n_clr, 120);
      chk("count wr_en", n_wr, 120);
      chk("count done", n_done, 1);
   endtask

   initial begin
      int n_late;
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      @(negedge clk);
      chk("reset busy", int'(c5_busy), 0);
      chk("reset acc", int'(c5_acc_en), 0);
      chk("reset waddr", int'(f6_waddr), 0);
      step();

      full_run(1'b1);
      repeat ($urandom_range(0, 5)) step();
      full_run(1'b0);

      // Mid-run reset.
      c5_start = 1'b1;
      step();
      c5_start = 1'b0;
      n_late = 0;
      for (int k = 0; k < 4600; k++) begin
         rst = (k == 1500);
         @(negedge clk);
         if (k == 1501) begin
            chk("rst busy", int'(c5_busy), 0);
            chk("rst acc", int'(c5_acc_en), 0);
            chk("rst clr", int'(c5_clr), 0);
            chk("rst f5", int'(f5_raddr), 0);
            chk("rst w", int'(w_raddr), 0);
            chk("rst waddr", int'(f6_waddr), 0);
         end
         if (k > 1500) n_late += int'(f6_wr_en) + int'(c5_done);
         step();
      end
      rst = 1'b0;
      chk("no strobe after rst", n_late, 0);

      // Reset together with start: reset wins.
      rst = 1'b1;
      c5_start = 1'b1;
      step();
      rst = 1'b0;
      c5_start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("rst+start busy", int'(c5_busy), 0);
         step();
      end

      // Random starts and occasional resets.
      for (int k = 0; k < 14000; k++) begin
         rst = ($urandom_range(0, 4999) == 0);
         c5_start = ($urandom_range(0, 99) == 0);
         step();
      end
      rst = 1'b0;
      c5_start = 1'b0;
      repeat (3) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
